// File: rtl/cpu_ctrl_pkg.sv
// Shared types and helpers for the LED-CPU execution sequencer.
//   state_t    : sequencer state, also driven out on the debug/LED port
//   rate_shift : run-rate shift table {0,4,8,DIV_W}, indexed by rate_sel
//   rate_k     : tick width K = DIV_W - shift, clamped at 0
package cpu_ctrl_pkg;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      HALT  = 2'd1,
      RUN   = 2'd2,
      STEP  = 2'd3
   } state_t;

   localparam int RATE_SHIFT_1 = 4;
   localparam int RATE_SHIFT_2 = 8;

   function automatic int rate_shift(input logic [1:0] sel, input int div_w);
      case (sel)
         2'd0:    return 0;
         2'd1:    return RATE_SHIFT_1;
         2'd2:    return RATE_SHIFT_2;
         default: return div_w;
      endcase
   endfunction

   // Number of low prescaler bits that must all be ones for a run tick.
   // A narrow prescaler can make DIV_W-8 negative; that case ticks every cycle.
   function automatic int rate_k(input logic [1:0] sel, input int div_w);
      int k;
      k = div_w - rate_shift(sel, div_w);
      return (k < 0) ? 0 : k;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, rising-edge pulse.
//   clk, rst : system clock, async active-high reset
//   btn_i    : raw button level (asynchronous)
//   pulse_o  : one-cycle pulse when a new high level has been accepted
// A level is accepted once DEB_CYC consecutive synchronised samples differ
// from the current accepted level; any sample that matches restarts the count.
module btn_debounce #(
   parameter int DEB_CYC = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic pulse_o
);

   localparam int CW = $clog2(DEB_CYC + 1);

   logic          sync1_q, sync2_q;
   logic          stable_q, stable_d;
   logic          pulse_q, pulse_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      stable_d = stable_q;
      pulse_d  = 1'b0;
      cnt_d    = cnt_q + CW'(1);
      if (sync2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CW'(DEB_CYC - 1)) begin
         stable_d = sync2_q;
         pulse_d  = sync2_q;   // only the 0->1 acceptance produces a pulse
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         pulse_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= btn_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         pulse_q  <= pulse_d;
         cnt_q    <= cnt_d;
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/cpu_exec_ctrl.sv
// Execution sequencer for the 8-bit LED CPU.
//   clk, rst          : system clock, async active-high reset
//   btn_run/step/clr  : raw board buttons (run/halt toggle, single step, core clear)
//   rate_sel          : run rate, one instruction per 2**K clks, K = DIV_W,DIV_W-4,DIV_W-8,0
//   bp_en, bp_adr, pc : PC breakpoint enable/address and live CPU program counter
//   cpu_ce            : one-cycle datapath enable (one instruction per high cycle)
//   cpu_rst_n         : active-low CPU core reset, low throughout CLEAR
//   state             : current sequencer state (state_t encoding)
//   bp_hit            : set when a breakpoint halts the CPU, cleared on leaving HALT
// All outputs come straight from flops.
module cpu_exec_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int DIV_W   = 24,
   parameter int DEB_CYC = 50000,
   parameter int CLR_CYC = 16,
   parameter int PC_W    = 11
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            btn_run,
   input  logic            btn_step,
   input  logic            btn_clr,
   input  logic [1:0]      rate_sel,
   input  logic            bp_en,
   input  logic [PC_W-1:0] bp_adr,
   input  logic [PC_W-1:0] pc,
   output logic            cpu_ce,
   output logic            cpu_rst_n,
   output logic [1:0]      state,
   output logic            bp_hit
);

   localparam int CNT_W = $clog2(CLR_CYC + 1);

   logic run_p, step_p, clr_p;

   btn_debounce #(.DEB_CYC(DEB_CYC)) u_run  (.clk(clk), .rst(rst), .btn_i(btn_run),  .pulse_o(run_p));
   btn_debounce #(.DEB_CYC(DEB_CYC)) u_step (.clk(clk), .rst(rst), .btn_i(btn_step), .pulse_o(step_p));
   btn_debounce #(.DEB_CYC(DEB_CYC)) u_clr  (.clk(clk), .rst(rst), .btn_i(btn_clr),  .pulse_o(clr_p));

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   presc_q, presc_d;
   logic [CNT_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic               ce_q, ce_d;
   logic               rst_n_q, rst_n_d;
   logic               hit_q, hit_d;
   logic               skip_q, skip_d;

   int                 k;
   logic [DIV_W-1:0]   k_mask;
   logic               tick;
   logic               bp_trig;

   // Rate tick: low K prescaler bits all ones. K=0 gives an empty mask, so
   // every cycle ticks; K=DIV_W ticks once per prescaler wrap.
   always_comb begin
      k       = rate_k(rate_sel, DIV_W);
      k_mask  = ~({DIV_W{1'b1}} << k);
      tick    = &(presc_q | ~k_mask);
      presc_d = presc_q + DIV_W'(1);
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      skip_d    = skip_q;
      ce_d      = 1'b0;
      bp_trig   = 1'b0;
      if (clr_p) begin
         state_d   = CLEAR;
         clr_cnt_d = '0;
      end else begin
         case (state_q)
            CLEAR: begin
               if (clr_cnt_q == CNT_W'(CLR_CYC - 1)) state_d = HALT;
               else                                  clr_cnt_d = clr_cnt_q + CNT_W'(1);
            end
            HALT: begin
               // Resuming from a breakpoint must execute the instruction at
               // bp_adr once, hence skip_bp until the first enable is issued.
               if (run_p) begin
                  state_d = RUN;
                  skip_d  = 1'b1;
               end else if (step_p) begin
                  state_d = STEP;
               end
            end
            RUN: begin
               if (run_p) begin
                  state_d = HALT;
               end else if (tick) begin
                  if (bp_en && (pc == bp_adr) && !skip_q) begin
                     state_d = HALT;
                     bp_trig = 1'b1;
                  end else begin
                     ce_d   = 1'b1;
                     skip_d = 1'b0;
                  end
               end
            end
            STEP: begin
               ce_d    = 1'b1;
               state_d = HALT;
            end
            default: state_d = CLEAR;
         endcase
      end
      hit_d   = (state_d == HALT) ? (hit_q | bp_trig) : 1'b0;
      rst_n_d = (state_d != CLEAR);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= CLEAR;
         presc_q   <= '0;
         clr_cnt_q <= '0;
         ce_q      <= 1'b0;
         rst_n_q   <= 1'b0;
         hit_q     <= 1'b0;
         skip_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         clr_cnt_q <= clr_cnt_d;
         ce_q      <= ce_d;
         rst_n_q   <= rst_n_d;
         hit_q     <= hit_d;
         skip_q    <= skip_d;
      end
   end

   assign cpu_ce    = ce_q;
   assign cpu_rst_n = rst_n_q;
   assign state     = state_q;
   assign bp_hit    = hit_q;

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Bench for cpu_exec_ctrl: table-driven step/rate vectors, hand sequences for
// breakpoint, clear and async reset, then randomized buttons against a
// behavioural model. The bench plays the CPU: pc advances on every cpu_ce and
// returns to 0 while cpu_rst_n is low.
module tb_cpu_exec_ctrl;

   localparam int DIV_W   = 8;
   localparam int DEB_CYC = 4;
   localparam int CLR_CYC = 8;
   localparam int PC_W    = 11;

   localparam int S_CLEAR = 0;
   localparam int S_HALT  = 1;
   localparam int S_RUN   = 2;
   localparam int S_STEP  = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            btn_run = 1'b0, btn_step = 1'b0, btn_clr = 1'b0;
   logic [1:0]      rate_sel = 2'd3;
   logic            bp_en = 1'b0;
   logic [PC_W-1:0] bp_adr = '0;
   logic [PC_W-1:0] pc = '0;
   logic            cpu_ce, cpu_rst_n, bp_hit;
   logic [1:0]      state;

   cpu_exec_ctrl #(.DIV_W(DIV_W), .DEB_CYC(DEB_CYC), .CLR_CYC(CLR_CYC), .PC_W(PC_W)) dut (
      .clk(clk), .rst(rst), .btn_run(btn_run), .btn_step(btn_step), .btn_clr(btn_clr),
      .rate_sel(rate_sel), .bp_en(bp_en), .bp_adr(bp_adr), .pc(pc),
      .cpu_ce(cpu_ce), .cpu_rst_n(cpu_rst_n), .state(state), .bp_hit(bp_hit)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int ce_cnt = 0;

   // ---------------- behavioural model ----------------
   int               m_state, m_clrcnt, m_presc;
   bit               m_ce, m_rstn, m_hit, m_skip;
   logic [DEB_CYC+1:0] m_hist [3];   // bit0 = newest raw sample
   bit               m_stab [3];
   bit               m_pend [3];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = S_CLEAR; m_clrcnt = 0; m_presc = 0;
      m_ce = 0; m_rstn = 0; m_hit = 0; m_skip = 0;
      for (int b = 0; b < 3; b++) begin
         m_hist[b] = '0; m_stab[b] = 0; m_pend[b] = 0;
      end
   endtask

   // One clock edge of the specified behaviour. A button pulse appears once a
   // synchronised (2-cycle delayed) window of DEB_CYC samples all shows the
   // opposite level; the FSM sees that pulse on the following edge.
   task automatic model_step();
      bit p [3];
      bit raw [3];
      int kk, nxt;
      bit tick, trig;
      p = m_pend;
      raw[0] = btn_run; raw[1] = btn_step; raw[2] = btn_clr;
      for (int b = 0; b < 3; b++) begin
         m_hist[b] = {m_hist[b][DEB_CYC:0], raw[b]};
         m_pend[b] = 1'b0;
         if (m_hist[b][DEB_CYC+1:2] == {DEB_CYC{~m_stab[b]}}) begin
            m_pend[b] = !m_stab[b];
            m_stab[b] = !m_stab[b];
         end
      end
      case (rate_sel)
         2'd0:    kk = DIV_W;
         2'd1:    kk = DIV_W - 4;
         2'd2:    kk = DIV_W - 8;
         default: kk = 0;
      endcase
      if (kk < 0) kk = 0;
      tick    = ((m_presc + 1) % (1 << kk)) == 0;
      m_presc = (m_presc + 1) % (1 << DIV_W);

      nxt = m_state; trig = 0; m_ce = 0;
      if (p[2]) begin
         nxt = S_CLEAR; m_clrcnt = 0;
      end else begin
         case (m_state)
            S_CLEAR: begin
               m_clrcnt++;
               if (m_clrcnt == CLR_CYC) nxt = S_HALT;
            end
            S_HALT: begin
               if (p[0]) begin nxt = S_RUN; m_skip = 1; end
               else if (p[1]) nxt = S_STEP;
            end
            S_RUN: begin
               if (p[0]) nxt = S_HALT;
               else if (tick) begin
                  if (bp_en && pc == bp_adr && !m_skip) begin nxt = S_HALT; trig = 1; end
                  else begin m_ce = 1; m_skip = 0; end
               end
            end
            default: begin m_ce = 1; nxt = S_HALT; end
         endcase
      end
      if (nxt != S_HALT) m_hit = 0;
      else if (trig) m_hit = 1;
      m_state = nxt;
      m_rstn  = (nxt != S_CLEAR);
   endtask

   // One clock: model follows the edge, DUT compared at the falling edge,
   // then the bench CPU reacts to the enable it just saw.
   task automatic cycle();
      int exp;
      @(posedge clk);
      if (!rst) model_step();
      @(negedge clk);
      exp = (m_state << 3) | (int'(m_ce) << 2) | (int'(m_rstn) << 1) | int'(m_hit);
      check("model", int'({state, cpu_ce, cpu_rst_n, bp_hit}), exp);
      if (cpu_ce) ce_cnt++;
      if (!cpu_rst_n) pc = '0;
      else if (cpu_ce) pc = pc + PC_W'(1);
   endtask

   task automatic set_btn(input int b, input logic v);
      case (b)
         0:       btn_run  = v;
         1:       btn_step = v;
         default: btn_clr  = v;
      endcase
   endtask

   task automatic press(input int b, input int hold);
      set_btn(b, 1'b1);
      repeat (hold) cycle();
      set_btn(b, 1'b0);
   endtask

   task automatic wait_state(input int target, input int budget, input string name, output int n);
      n = 0;
      while (int'(state) != target && n < budget) begin
         cycle();
         n++;
      end
      check(name, int'(state), target);
   endtask

   typedef struct { int hold; int exp_ce; } step_vec_t;
   typedef struct { logic [1:0] sel; int period; } rate_vec_t;
   step_vec_t step_tbl [4];
   rate_vec_t rate_tbl [4];

   initial begin
      int n, w;
      step_tbl[0] = '{hold: 10, exp_ce: 1};
      step_tbl[1] = '{hold: 2,  exp_ce: 0};
      step_tbl[2] = '{hold: 3,  exp_ce: 0};
      step_tbl[3] = '{hold: 4,  exp_ce: 1};
      rate_tbl[0] = '{sel: 2'd3, period: 1};
      rate_tbl[1] = '{sel: 2'd2, period: 1};
      rate_tbl[2] = '{sel: 2'd1, period: 16};
      rate_tbl[3] = '{sel: 2'd0, period: 256};

      // reset and CLEAR length
      model_reset();
      rst = 1'b1;
      repeat (2) cycle();
      check("rst_state", int'(state), S_CLEAR);
      check("rst_ce", int'(cpu_ce), 0);
      check("rst_rstn", int'(cpu_rst_n), 0);
      check("rst_bphit", int'(bp_hit), 0);
      rst = 1'b0;
      n = 0;
      while (!cpu_rst_n && n < 50) begin cycle(); n++; end
      check("clear_len", n, CLR_CYC);
      check("halt_after_clear", int'(state), S_HALT);
      check("ce_after_clear", int'(cpu_ce), 0);

      // single step: held button, glitches, debounce boundary
      foreach (step_tbl[i]) begin
         ce_cnt = 0;
         press(1, step_tbl[i].hold);
         repeat (DEB_CYC + 8) cycle();
         check($sformatf("step_hold%0d", step_tbl[i].hold), ce_cnt, step_tbl[i].exp_ce);
         check("step_back_halt", int'(state), S_HALT);
      end

      // run rates
      press(0, 6);
      wait_state(S_RUN, 20, "enter_run", n);
      foreach (rate_tbl[i]) begin
         rate_sel = rate_tbl[i].sel;
         repeat (3) cycle();
         w = (rate_tbl[i].period == 1) ? 16 : 2 * rate_tbl[i].period;
         ce_cnt = 0;
         repeat (w) cycle();
         check($sformatf("rate_sel%0d_pulses", rate_tbl[i].sel), ce_cnt, w / rate_tbl[i].period);
      end
      press(0, 6);
      wait_state(S_HALT, 20, "run_to_halt", n);

      // breakpoint at pc=5 from a freshly cleared core
      press(2, 6);
      wait_state(S_CLEAR, 20, "clr_from_halt", n);
      wait_state(S_HALT, 30, "clr_done", n);
      rate_sel = 2'd3; bp_en = 1'b1; bp_adr = PC_W'(5);
      press(0, 6);
      wait_state(S_RUN, 20, "bp_run", n);
      wait_state(S_HALT, 50, "bp_halt", n);
      check("bp_pc", int'(pc), 5);
      check("bp_hit_set", int'(bp_hit), 1);
      press(0, 6);
      wait_state(S_RUN, 20, "bp_resume", n);
      check("bp_hit_clr", int'(bp_hit), 0);
      repeat (4) cycle();
      check("bp_continue_pc", int'(pc), 9);

      // clear while running: enable stops on the CLEAR edge
      set_btn(2, 1'b1);
      wait_state(S_CLEAR, 20, "clr_from_run", n);
      check("clr_run_ce", int'(cpu_ce), 0);
      check("clr_run_rstn", int'(cpu_rst_n), 0);
      set_btn(2, 1'b0);
      wait_state(S_HALT, 30, "clr_run_halt", n);
      check("clr_run_len", n, CLR_CYC);

      // clear and run pulses together: clear wins
      btn_clr = 1'b1; btn_run = 1'b1;
      repeat (6) cycle();
      btn_clr = 1'b0; btn_run = 1'b0;
      wait_state(S_CLEAR, 20, "clr_beats_run", n);
      wait_state(S_HALT, 30, "clr_beats_run_halt", n);

      // async reset between edges while running
      bp_en = 1'b0;
      press(0, 6);
      wait_state(S_RUN, 20, "async_run", n);
      repeat (3) cycle();
      check("async_pre_ce", int'(cpu_ce), 1);
      #2 rst = 1'b1;
      #1;
      check("async_ce", int'(cpu_ce), 0);
      check("async_rstn", int'(cpu_rst_n), 0);
      check("async_state", int'(state), S_CLEAR);
      model_reset();
      pc = '0;
      cycle();
      rst = 1'b0;
      wait_state(S_HALT, 30, "async_recover", n);

      // randomized buttons and settings against the model
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 7) == 0) btn_run = ~btn_run;
         if ($urandom_range(0, 5) == 0) btn_step = ~btn_step;
         if ($urandom_range(0, 99) == 0) btn_clr = ~btn_clr;
         if ($urandom_range(0, 299) == 0)
            rate_sel = ($urandom_range(0, 1) == 1) ? 2'd3 : 2'($urandom_range(0, 3));
         if ($urandom_range(0, 49) == 0) begin
            bp_en  = 1'($urandom_range(0, 1));
            bp_adr = pc + PC_W'($urandom_range(0, 6));
         end
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
